// File: rtl/dcpu_bus_arbiter.sv
// rtl/dcpu_bus_arbiter.sv - two-master round-robin bus arbiter with burst preemption and ack timeout
module dcpu_bus_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_cyc,
  input  logic [1:0]  i_m0_stb,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [15:0] i_m0_dat,
  input  logic        i_m1_cyc,
  input  logic [1:0]  i_m1_stb,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [15:0] i_m1_dat,
  output logic        o_m0_ack,
  output logic [15:0] o_m0_dat,
  output logic        o_m1_ack,
  output logic [15:0] o_m1_dat,
  output logic        o_cyc,
  output logic [1:0]  o_stb,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [15:0] o_dat,
  input  logic        i_ack,
  input  logic [15:0] i_dat,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [8:0] BURST_LIM = 9'(MAX_BURST);

  state_t      state;
  logic        last_owner;
  logic [7:0]  burst_cnt;
  logic [7:0]  to_cnt;

  logic        granted, owner, own_cyc, oth_cyc;
  logic        timeout_hit, ack_any, burst_done;
  logic [15:0] rd_dat;

  always_comb begin
    granted     = (state == GRANT0) || (state == GRANT1);
    owner       = (state == GRANT1);
    own_cyc     = owner ? i_m1_cyc : i_m0_cyc;
    oth_cyc     = owner ? i_m0_cyc : i_m1_cyc;
    // A real ack in the last timeout cycle wins over the generated one.
    timeout_hit = granted && own_cyc && !i_ack && (to_cnt == TO_LAST);
    ack_any     = granted && own_cyc && (i_ack || timeout_hit);
    burst_done  = ({1'b0, burst_cnt} + 9'd1) >= BURST_LIM;
    rd_dat      = timeout_hit ? 16'hDEAD : i_dat;
  end

  always_comb begin
    o_cyc     = 1'b0;
    o_stb     = 2'b00;
    o_we      = 1'b0;
    o_addr    = 32'd0;
    o_dat     = 16'd0;
    o_m0_ack  = 1'b0;
    o_m0_dat  = 16'd0;
    o_m1_ack  = 1'b0;
    o_m1_dat  = 16'd0;
    o_grant   = {state == GRANT1, state == GRANT0};
    o_timeout = timeout_hit;
    if (state == GRANT0) begin
      o_cyc    = i_m0_cyc && !timeout_hit;
      o_stb    = timeout_hit ? 2'b00 : i_m0_stb;
      o_we     = i_m0_we;
      o_addr   = i_m0_addr;
      o_dat    = i_m0_dat;
      o_m0_ack = ack_any;
      o_m0_dat = rd_dat;
    end else if (state == GRANT1) begin
      o_cyc    = i_m1_cyc && !timeout_hit;
      o_stb    = timeout_hit ? 2'b00 : i_m1_stb;
      o_we     = i_m1_we;
      o_addr   = i_m1_addr;
      o_dat    = i_m1_dat;
      o_m1_ack = ack_any;
      o_m1_dat = rd_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= 8'd0;
      to_cnt     <= 8'd0;
    end else begin
      case (state)
        GRANT0, GRANT1: begin
          if (!own_cyc) begin
            state      <= IDLE;
            last_owner <= owner;
            burst_cnt  <= 8'd0;
            to_cnt     <= 8'd0;
          end else if (ack_any && oth_cyc && burst_done) begin
            state      <= owner ? GRANT0 : GRANT1;
            last_owner <= owner;
            burst_cnt  <= 8'd0;
            to_cnt     <= 8'd0;
          end else begin
            to_cnt <= ack_any ? 8'd0 : to_cnt + 8'd1;
            // Burst length only matters while the other master is waiting.
            if (!oth_cyc)
              burst_cnt <= 8'd0;
            else if (ack_any && burst_cnt != 8'hFF)
              burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: begin
          burst_cnt <= 8'd0;
          to_cnt    <= 8'd0;
          if (i_m0_cyc && i_m1_cyc)
            state <= last_owner ? GRANT0 : GRANT1;
          else if (i_m0_cyc)
            state <= GRANT0;
          else if (i_m1_cyc)
            state <= GRANT1;
          else
            state <= IDLE;
        end
      endcase
    end
  end

endmodule
